// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory-access stage: mem_op codes, exception codes,
// controller states and small op-classification helpers.
package mem_ctrl_pkg;

  localparam int MEM_OP_W = 4;
  localparam int EXP_W    = 3;

  typedef enum logic [MEM_OP_W-1:0] {
    MEM_OP_NOP = 4'd0,
    MEM_OP_LW  = 4'd1,
    MEM_OP_LH  = 4'd2,
    MEM_OP_LHU = 4'd3,
    MEM_OP_LB  = 4'd4,
    MEM_OP_LBU = 4'd5,
    MEM_OP_SW  = 4'd6,
    MEM_OP_SH  = 4'd7,
    MEM_OP_SB  = 4'd8
  } mem_op_e;

  localparam logic [EXP_W-1:0] ISA_EXP_NO_EXP         = 3'd0;
  localparam logic [EXP_W-1:0] ISA_EXP_UNDEF_INSN     = 3'd1;
  localparam logic [EXP_W-1:0] ISA_EXP_LOAD_MISALIGN  = 3'd2;
  localparam logic [EXP_W-1:0] ISA_EXP_STORE_MISALIGN = 3'd3;
  localparam logic [EXP_W-1:0] ISA_EXP_BUS_ERR        = 3'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic op_is_load(input logic [MEM_OP_W-1:0] op);
    return (op == MEM_OP_LW) || (op == MEM_OP_LH) || (op == MEM_OP_LHU) ||
           (op == MEM_OP_LB) || (op == MEM_OP_LBU);
  endfunction

  function automatic logic op_is_store(input logic [MEM_OP_W-1:0] op);
    return (op == MEM_OP_SW) || (op == MEM_OP_SH) || (op == MEM_OP_SB);
  endfunction

  // Byte accesses can never be misaligned.
  function automatic logic op_misaligned(input logic [MEM_OP_W-1:0] op, input logic [1:0] lo);
    if ((op == MEM_OP_LW) || (op == MEM_OP_SW)) return lo != 2'b00;
    if ((op == MEM_OP_LH) || (op == MEM_OP_LHU) || (op == MEM_OP_SH)) return lo[0];
    return 1'b0;
  endfunction

endpackage

// File: rtl/mem_ctrl_load_align.sv
// Load data extraction: selects the addressed byte/halfword lane of the read
// word and sign- or zero-extends it to 32 bits.
module mem_ctrl_load_align
  import mem_ctrl_pkg::*;
(
  input  logic [MEM_OP_W-1:0] op,
  input  logic [1:0]          addr_lo,
  input  logic [31:0]         rdata,
  output logic [31:0]         data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      MEM_OP_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      MEM_OP_LBU: data = {24'd0, byte_sel};
      MEM_OP_LH:  data = {{16{half_sel[15]}}, half_sel};
      MEM_OP_LHU: data = {16'd0, half_sel};
      default:    data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory-access pipeline stage: issues one req/ack bus transaction per aligned
// load/store, stalls upstream while it is outstanding, and emits a writeback pulse.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [MEM_OP_W-1:0] mem_op,
  input  logic [31:0]         alu_out,
  input  logic [31:0]         gpr_data,
  input  logic [4:0]          dst_addr,
  input  logic                gpr_we_,
  output logic                stall,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-3:0]   bus_addr,
  output logic [3:0]          bus_be,
  output logic [31:0]         bus_wdata,
  input  logic [31:0]         bus_rdata,
  input  logic                bus_ack,
  output logic                wb_valid,
  output logic [4:0]          wb_dst_addr,
  output logic [31:0]         wb_data,
  output logic                wb_we_,
  output logic [EXP_W-1:0]    exp_code
);

  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [MEM_OP_W-1:0] op_q, op_d;
  logic [1:0]          addr_lo_q, addr_lo_d;
  logic [4:0]          dst_q, dst_d;
  logic                we_q, we_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-3:0]   bus_addr_q, bus_addr_d;
  logic [3:0]          bus_be_q, bus_be_d;
  logic [31:0]         bus_wdata_q, bus_wdata_d;
  logic                wb_valid_q, wb_valid_d;
  logic [4:0]          wb_dst_q, wb_dst_d;
  logic [31:0]         wb_data_q, wb_data_d;
  logic                wb_we_q, wb_we_d;
  logic [EXP_W-1:0]    exp_q, exp_d;

  logic [31:0] load_data;
  logic        in_is_mem;
  logic        in_is_undef;

  mem_ctrl_load_align u_load_align (
    .op      (op_q),
    .addr_lo (addr_lo_q),
    .rdata   (bus_rdata),
    .data    (load_data)
  );

  assign in_is_mem   = op_is_load(mem_op) || op_is_store(mem_op);
  assign in_is_undef = !in_is_mem && (mem_op != MEM_OP_NOP);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_lo_d   = addr_lo_q;
    dst_d       = dst_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    wb_valid_d  = 1'b0;
    wb_dst_d    = wb_dst_q;
    wb_data_d   = wb_data_q;
    wb_we_d     = wb_we_q;
    exp_d       = exp_q;
    stall       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          wb_dst_d  = dst_addr;
          wb_data_d = alu_out;
          if (!in_is_mem) begin
            // NOP passthrough, or an undefined op reported as an exception.
            wb_valid_d = 1'b1;
            wb_we_d    = in_is_undef ? 1'b1 : gpr_we_;
            exp_d      = in_is_undef ? ISA_EXP_UNDEF_INSN : ISA_EXP_NO_EXP;
          end else if (op_misaligned(mem_op, alu_out[1:0])) begin
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b1;
            exp_d      = op_is_store(mem_op) ? ISA_EXP_STORE_MISALIGN : ISA_EXP_LOAD_MISALIGN;
          end else begin
            stall      = 1'b1;
            state_d    = ST_BUSY;
            op_d       = mem_op;
            addr_lo_d  = alu_out[1:0];
            dst_d      = dst_addr;
            we_d       = gpr_we_;
            cnt_d      = 4'd0;
            bus_req_d  = 1'b1;
            bus_we_d   = op_is_store(mem_op);
            bus_addr_d = alu_out[ADDR_W-1:2];
            case (mem_op)
              MEM_OP_SH: begin
                bus_be_d    = alu_out[1] ? 4'b1100 : 4'b0011;
                bus_wdata_d = {2{gpr_data[15:0]}};
              end
              MEM_OP_SB: begin
                bus_be_d    = 4'b0001 << alu_out[1:0];
                bus_wdata_d = {4{gpr_data[7:0]}};
              end
              default: begin
                bus_be_d    = 4'b1111;
                bus_wdata_d = gpr_data;
              end
            endcase
          end
        end
      end

      ST_BUSY: begin
        stall = 1'b1;
        if (bus_ack || (cnt_q == CNT_LAST)) begin
          // An ack on the final counted cycle still completes normally.
          state_d    = ST_IDLE;
          bus_req_d  = 1'b0;
          cnt_d      = 4'd0;
          wb_valid_d = 1'b1;
          wb_dst_d   = dst_q;
          if (!bus_ack) begin
            wb_data_d = 32'd0;
            wb_we_d   = 1'b1;
            exp_d     = ISA_EXP_BUS_ERR;
          end else if (op_is_store(op_q)) begin
            wb_data_d = 32'd0;
            wb_we_d   = 1'b1;
            exp_d     = ISA_EXP_NO_EXP;
          end else begin
            wb_data_d = load_data;
            wb_we_d   = we_q;
            exp_d     = ISA_EXP_NO_EXP;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= MEM_OP_NOP;
      addr_lo_q   <= 2'd0;
      dst_q       <= 5'd0;
      we_q        <= 1'b1;
      cnt_q       <= 4'd0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= 4'd0;
      bus_wdata_q <= 32'd0;
      wb_valid_q  <= 1'b0;
      wb_dst_q    <= 5'd0;
      wb_data_q   <= 32'd0;
      wb_we_q     <= 1'b1;
      exp_q       <= ISA_EXP_NO_EXP;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_lo_q   <= addr_lo_d;
      dst_q       <= dst_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_dst_q    <= wb_dst_d;
      wb_data_q   <= wb_data_d;
      wb_we_q     <= wb_we_d;
      exp_q       <= exp_d;
    end
  end

  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_be      = bus_be_q;
  assign bus_wdata   = bus_wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_dst_addr = wb_dst_q;
  assign wb_data     = wb_data_q;
  assign wb_we_      = wb_we_q;
  assign exp_code    = exp_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed corner cases plus randomized transactions checked
// against an arithmetic reference of byte-lane placement and load extension.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  mem_op;
  logic [31:0] alu_out;
  logic [31:0] gpr_data;
  logic [4:0]  dst_addr;
  logic        gpr_we_;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        wb_valid;
  logic [4:0]  wb_dst_addr;
  logic [31:0] wb_data;
  logic        wb_we_;
  logic [2:0]  exp_code;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_op(mem_op), .alu_out(alu_out),
    .gpr_data(gpr_data), .dst_addr(dst_addr), .gpr_we_(gpr_we_), .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .wb_valid(wb_valid), .wb_dst_addr(wb_dst_addr), .wb_data(wb_data),
    .wb_we_(wb_we_), .exp_code(exp_code)
  );

  // Reference model: access size in bytes, lane placement and extension by arithmetic.
  function automatic int ref_size(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd6) return 4;
    if (op == 4'd2 || op == 4'd3 || op == 4'd7) return 2;
    return 1;
  endfunction

  function automatic bit ref_misalign(input logic [3:0] op, input logic [31:0] addr);
    return (addr % ref_size(op)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [3:0] op, input logic [31:0] addr);
    int sz;
    sz = ref_size(op);
    return 4'(((1 << sz) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [3:0] op, input logic [31:0] d);
    if (ref_size(op) == 4) return d;
    if (ref_size(op) == 2) return (d % 65536) * 32'h0001_0001;
    return (d % 256) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (addr % 4));
    case (op)
      4'd2: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
      4'd3: v = v % 65536;
      4'd4: begin v = v % 256; if (v >= 128) v = v - 256; end
      4'd5: v = v % 256;
      default: v = rd;
    endcase
    return v;
  endfunction

  task automatic mem_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rdata, input int wait_n, input string tag);
    logic [4:0]  dst;
    logic        wen;
    bit          undef, is_mem, is_st, mis;
    logic [31:0] e_data;
    logic        e_we;
    logic [2:0]  e_exp;
    dst    = 5'($urandom);
    wen    = 1'($urandom);
    undef  = op > 4'd8;
    is_mem = !undef && op != 4'd0;
    is_st  = op >= 4'd6 && op <= 4'd8;
    mis    = is_mem && ref_misalign(op, addr);
    @(negedge clk);
    in_valid = 1'b1; mem_op = op; alu_out = addr; gpr_data = data;
    dst_addr = dst; gpr_we_ = wen;
    #1;
    if (!mis) begin
      n_vec++;
      if (stall !== (is_mem ? 1'b1 : 1'b0)) begin
        n_err++; $display("FAIL %s issue_stall: got %b want %b", tag, stall, is_mem);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; mem_op = 4'($urandom); alu_out = $urandom; gpr_data = $urandom;
    if (is_mem && !mis) begin
      n_vec++;
      if (bus_req !== 1'b1 || bus_we !== is_st || bus_addr !== addr[31:2] ||
          bus_be !== (is_st ? ref_be(op, addr) : 4'hF)) begin
        n_err++;
        $display("FAIL %s bus_issue: got req=%b we=%b addr=%h be=%b want req=1 we=%b addr=%h be=%b",
                 tag, bus_req, bus_we, bus_addr, bus_be, is_st, addr[31:2],
                 is_st ? ref_be(op, addr) : 4'hF);
      end
      if (is_st) begin
        n_vec++;
        if (bus_wdata !== ref_wdata(op, data)) begin
          n_err++; $display("FAIL %s bus_wdata: got %h want %h", tag, bus_wdata, ref_wdata(op, data));
        end
      end
      for (int i = 0; i < wait_n; i++) begin
        n_vec++;
        if (bus_req !== 1'b1 || wb_valid !== 1'b0 || stall !== 1'b1) begin
          n_err++; $display("FAIL %s busy_hold[%0d]: got req=%b wbv=%b stall=%b want 1 0 1",
                            tag, i, bus_req, wb_valid, stall);
        end
        @(negedge clk);
      end
      bus_ack = 1'b1; bus_rdata = rdata;
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = $urandom;
      e_data = is_st ? 32'd0 : ref_load(op, addr, rdata);
      e_we   = is_st ? 1'b1 : wen;
      e_exp  = ISA_EXP_NO_EXP;
    end else begin
      e_data = addr;
      e_we   = (op == 4'd0) ? wen : 1'b1;
      e_exp  = undef ? ISA_EXP_UNDEF_INSN :
               mis ? (is_st ? ISA_EXP_STORE_MISALIGN : ISA_EXP_LOAD_MISALIGN) : ISA_EXP_NO_EXP;
    end
    n_vec++;
    if (wb_valid !== 1'b1 || bus_req !== 1'b0 || wb_dst_addr !== dst ||
        wb_we_ !== e_we || exp_code !== e_exp) begin
      n_err++;
      $display("FAIL %s wb_ctrl: got v=%b req=%b dst=%0d we_=%b exp=%0d want 1 0 %0d %b %0d",
               tag, wb_valid, bus_req, wb_dst_addr, wb_we_, exp_code, dst, e_we, e_exp);
    end
    if (!mis) begin
      n_vec++;
      if (wb_data !== e_data) begin
        n_err++; $display("FAIL %s wb_data: got %h want %h", tag, wb_data, e_data);
      end
    end
    @(negedge clk);
    n_vec++;
    if (wb_valid !== 1'b0) begin
      n_err++; $display("FAIL %s wb_pulse_len: got %b want 0", tag, wb_valid);
    end
    $display("txn %-10s op=%0d addr=%h data=%h wait=%0d -> wb_data=%h we_=%b exp=%0d",
             tag, op, addr, data, wait_n, e_data, e_we, e_exp);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; mem_op = 4'd0; alu_out = 32'd0; gpr_data = 32'd0;
    dst_addr = 5'd0; gpr_we_ = 1'b1; bus_ack = 1'b0; bus_rdata = 32'd0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== '0 || stall !== 1'b0) begin
      n_err++; $display("FAIL reset_bus: got req=%b we=%b addr=%h be=%b wdata=%h stall=%b want zeros",
                        bus_req, bus_we, bus_addr, bus_be, bus_wdata, stall);
    end
    n_vec++;
    if (wb_valid !== 1'b0 || wb_dst_addr !== 5'd0 || wb_data !== 32'd0 ||
        wb_we_ !== 1'b1 || exp_code !== ISA_EXP_NO_EXP) begin
      n_err++; $display("FAIL reset_wb: got v=%b dst=%0d data=%h we_=%b exp=%0d want 0 0 0 1 0",
                        wb_valid, wb_dst_addr, wb_data, wb_we_, exp_code);
    end
    rst = 1'b0;
    $display("txn reset");
  endtask

  task automatic test_directed();
    mem_txn(4'd8, 32'h0000_1003, 32'h0000_00A5, 32'h0, 2, "sb_1003");
    mem_txn(4'd4, 32'h0000_2002, 32'h0, 32'h0080_0000, 0, "lb_2002");
    mem_txn(4'd5, 32'h0000_2002, 32'h0, 32'h0080_0000, 1, "lbu_2002");
    mem_txn(4'd1, 32'h0000_3002, 32'h0, 32'h0, 0, "lw_mis");
    mem_txn(4'd7, 32'h0000_0001, 32'h0, 32'h0, 0, "sh_mis");
    mem_txn(4'd7, 32'h0000_0002, 32'hDEAD_1234, 32'h0, 0, "sh_hi");
    mem_txn(4'd2, 32'h0000_0006, 32'h0, 32'h8001_7FFF, 3, "lh_hi");
    mem_txn(4'd1, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 14, "lw_ack_last");
    mem_txn(4'd12, 32'h0000_0055, 32'h0, 32'h0, 0, "undef_op");
  endtask

  task automatic test_timeout();
    int cnt;
    @(negedge clk);
    in_valid = 1'b1; mem_op = 4'd1; alu_out = 32'h0000_5000; dst_addr = 5'd3; gpr_we_ = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus_req !== 1'b1) break;
      cnt++;
      @(negedge clk);
    end
    n_vec++;
    if (cnt != 15) begin
      n_err++; $display("FAIL timeout_len: got %0d busy cycles want 15", cnt);
    end
    n_vec++;
    if (wb_valid !== 1'b1 || wb_we_ !== 1'b1 || exp_code !== ISA_EXP_BUS_ERR || bus_req !== 1'b0) begin
      n_err++; $display("FAIL timeout_wb: got v=%b we_=%b exp=%0d req=%b want 1 1 %0d 0",
                        wb_valid, wb_we_, exp_code, bus_req, ISA_EXP_BUS_ERR);
    end
    $display("txn timeout busy_cycles=%0d", cnt);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_valid = 1'b1; mem_op = 4'd0; alu_out = 32'h11; dst_addr = 5'd1; gpr_we_ = 1'b0;
    #1;
    n_vec++;
    if (stall !== 1'b0) begin n_err++; $display("FAIL b2b_stall0: got %b want 0", stall); end
    @(negedge clk);
    alu_out = 32'h22; dst_addr = 5'd2;
    #1;
    n_vec++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h11 || stall !== 1'b0 || wb_dst_addr !== 5'd1) begin
      n_err++; $display("FAIL b2b_first: got v=%b data=%h stall=%b dst=%0d want 1 11 0 1",
                        wb_valid, wb_data, stall, wb_dst_addr);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h22 || stall !== 1'b0 || wb_dst_addr !== 5'd2) begin
      n_err++; $display("FAIL b2b_second: got v=%b data=%h stall=%b dst=%0d want 1 22 0 2",
                        wb_valid, wb_data, stall, wb_dst_addr);
    end
    $display("txn back_to_back nop 0x11,0x22");
  endtask

  task automatic test_reset_mid_busy();
    bit seen_wb;
    @(negedge clk);
    in_valid = 1'b1; mem_op = 4'd6; alu_out = 32'h0000_6000; gpr_data = 32'h1234_5678;
    dst_addr = 5'd7; gpr_we_ = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus_req !== 1'b0 || bus_be !== 4'd0 || bus_wdata !== 32'd0 || bus_addr !== 30'd0 ||
        wb_valid !== 1'b0 || wb_we_ !== 1'b1 || stall !== 1'b0) begin
      n_err++; $display("FAIL rst_busy_async: got req=%b be=%b wdata=%h v=%b we_=%b stall=%b want reset values",
                        bus_req, bus_be, bus_wdata, wb_valid, wb_we_, stall);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_wb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wb_valid === 1'b1 || bus_req === 1'b1) seen_wb = 1;
    end
    n_vec++;
    if (seen_wb) begin n_err++; $display("FAIL rst_busy_after: got activity want none"); end
    $display("txn reset_mid_busy sw");
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] addr;
    int          k;
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 9);
      op = (k == 9) ? 4'(12 + $urandom_range(0, 3)) : 4'(k);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      else if ($urandom_range(0, 1) != 0) addr[0] = 1'b0;
      mem_txn(op, addr, $urandom, $urandom, $urandom_range(0, 14), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
